bsg_two_fifo_bypass: RTL and testbench



---
 rtl/bsg_dff_en.sv | 15 +
 rtl/bsg_two_fifo_bypass_mem.sv | 26 ++
 rtl/bsg_two_fifo_bypass.sv | 75 +++++++
 tb/tb_bsg_two_fifo_bypass.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bsg_dff_en.sv
// Plain enable flop with no reset; holds its value when en_i is low.
module bsg_dff_en #(
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i) begin
    if (en_i) data_o <= data_i;
  end

endmodule

// File: rtl/bsg_two_fifo_bypass_mem.sv
// Two-slot payload storage for the bypass FIFO: per-slot write enables and a read mux.
module bsg_two_fifo_bypass_mem #(
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               wr_i,
  input  logic               wptr_i,
  input  logic [width_p-1:0] data_i,
  input  logic               rptr_i,
  output logic [width_p-1:0] data_o
);

  logic [1:0][width_p-1:0] slot;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    bsg_dff_en #(.width_p(width_p)) dff (
      .clk_i (clk_i),
      .en_i  (wr_i & (wptr_i == 1'(i))),
      .data_i(data_i),
      .data_o(slot[i])
    );
  end

  assign data_o = slot[rptr_i];

endmodule

// File: rtl/bsg_two_fifo_bypass.sv
// Two-entry ready/valid skid stage; an empty stage passes data_i straight through.
// ready_o depends only on registered state and reset, never on yumi_i.
module bsg_two_fifo_bypass #(
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]         count_r, count_n;
  logic               rptr_r, wptr_r;
  logic               enq, deq, bypass_take, wr, rd;
  logic [width_p-1:0] mem_data;

  assign ready_o     = ~reset_i & (count_r != FULL);
  assign v_o         = ~reset_i & ((count_r != EMPTY) | v_i);
  assign enq         = v_i & ready_o;
  assign deq         = yumi_i;
  // A beat consumed in the same cycle it arrives into an empty stage never touches storage.
  assign bypass_take = enq & yumi_i & (count_r == EMPTY);
  assign wr          = enq & ~bypass_take;
  assign rd          = deq & ~bypass_take;

  bsg_two_fifo_bypass_mem #(.width_p(width_p)) mem (
    .clk_i (clk_i),
    .wr_i  (wr),
    .wptr_i(wptr_r),
    .data_i(data_i),
    .rptr_i(rptr_r),
    .data_o(mem_data)
  );

  assign data_o = (count_r == EMPTY) ? data_i : mem_data;

  always_comb begin
    count_n = count_r;
    case (count_r)
      EMPTY:   if (enq & ~yumi_i) count_n = ONE;
      ONE: begin
        if (enq & ~deq)      count_n = FULL;
        else if (deq & ~enq) count_n = EMPTY;
      end
      FULL:    if (deq) count_n = ONE;
      default: count_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= EMPTY;
      rptr_r  <= 1'b0;
      wptr_r  <= 1'b0;
    end else begin
      count_r <= count_n;
      if (wr) wptr_r <= ~wptr_r;
      if (rd) rptr_r <= ~rptr_r;
    end
  end

`ifndef SYNTHESIS
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
    else $error("bsg_two_fifo_bypass: yumi_i asserted while v_o is low");
`endif

endmodule

// File: tb/tb_bsg_two_fifo_bypass.sv
// Scoreboard bench for bsg_two_fifo_bypass: queue model of stored beats, checked mid-cycle.
module tb_bsg_two_fifo_bypass;
  localparam int W = 128;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         v_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         ready_o, v_o, yumi_i = 1'b0;
  logic [W-1:0] data_o;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] q[$];

  bsg_two_fifo_bypass #(.width_p(W)) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .v_i    (v_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .v_o    (v_o),
    .data_o (data_o),
    .yumi_i (yumi_i)
  );

  always #5 clk = ~clk;

  // Apply inputs just after a negedge and let combinational outputs settle.
  task automatic drive(input bit v, input logic [W-1:0] d, input bit y);
    v_i = v; data_i = d; yumi_i = y;
    #1;
  endtask

  // Advance the model across the next posedge, then return at the following negedge.
  task automatic commit();
    if (reset_i) q.delete();
    else begin
      if (v_i && q.size() < 2) q.push_back(data_i);
      if (yumi_i && q.size() > 0) void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] exp_data();
    return (q.size() > 0) ? q[0] : data_i;
  endfunction

  task automatic test_reset();
    reset_i = 1'b1;
    drive(1, 'h55, 0);
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", ready_o); end
    checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL reset_v got=%0b exp=0", v_o); end
    commit();
    reset_i = 1'b0;
    drive(0, '0, 0);
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%0b exp=1", ready_o); end
    checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL post_reset_v got=%0b exp=0", v_o); end
  endtask

  task automatic test_bypass();
    logic [W-1:0] a5;
    a5 = {16{8'hA5}};
    drive(1, a5, 1);
    checks++; if (v_o !== 1'b1) begin failures++; $display("FAIL bypass_v got=%0b exp=1", v_o); end
    checks++; if (data_o !== a5) begin failures++; $display("FAIL bypass_data got=%h exp=%h", data_o, a5); end
    commit();
    drive(0, '0, 0);
    checks++; if (ready_o !== 1'b1 || v_o !== 1'b0) begin failures++; $display("FAIL bypass_after ready=%0b v=%0b exp ready=1 v=0", ready_o, v_o); end
  endtask

  task automatic test_fill();
    drive(1, 'h1, 0); commit();
    drive(1, 'h2, 0);
    checks++; if (data_o !== W'('h1) || ready_o !== 1'b1) begin failures++; $display("FAIL fill_one data=%h ready=%0b exp data=1 ready=1", data_o, ready_o); end
    commit();
    drive(1, 'h3, 0);
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%0b exp=0", ready_o); end
    checks++; if (data_o !== W'('h1)) begin failures++; $display("FAIL fill_full_data got=%h exp=1", data_o); end
    commit();
    for (int i = 1; i <= 2; i++) begin
      drive(0, '0, 1);
      checks++; if (data_o !== exp_data() || data_o !== W'(i)) begin failures++; $display("FAIL fill_drain%0d got=%h exp=%h", i, data_o, W'(i)); end
      commit();
    end
    drive(0, '0, 0);
    checks++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin failures++; $display("FAIL fill_empty v=%0b ready=%0b exp v=0 ready=1", v_o, ready_o); end
  endtask

  task automatic test_simultaneous();
    drive(1, 'h7, 0); commit();
    drive(1, 'h8, 1);
    checks++; if (data_o !== W'('h7) || ready_o !== 1'b1) begin failures++; $display("FAIL simul_now data=%h ready=%0b exp data=7 ready=1", data_o, ready_o); end
    commit();
    drive(0, '0, 1);
    checks++; if (data_o !== W'('h8) || v_o !== 1'b1) begin failures++; $display("FAIL simul_next data=%h v=%0b exp data=8 v=1", data_o, v_o); end
    commit();
    drive(0, '0, 0);
    checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL simul_empty got=%0b exp=0", v_o); end
  endtask

  task automatic test_back_to_back();
    int bubbles = 0;
    drive(1, '0, 0); commit();
    for (int i = 1; i <= 10; i++) begin
      if (i < 10) drive(1, W'(i), 1);
      else drive(0, '0, 1);
      checks++; if (data_o !== W'(i - 1) || v_o !== 1'b1) begin failures++; $display("FAIL stream_beat%0d got=%h v=%0b exp=%h", i - 1, data_o, v_o, W'(i - 1)); end
      if (ready_o !== 1'b1) bubbles++;
      commit();
    end
    checks++; if (bubbles != 0) begin failures++; $display("FAIL stream_bubbles got=%0d exp=0", bubbles); end
    drive(0, '0, 0);
    checks++; if (v_o !== 1'b0 || q.size() != 0) begin failures++; $display("FAIL stream_empty v=%0b q=%0d exp v=0 q=0", v_o, q.size()); end
  endtask

  task automatic test_reset_mid();
    drive(1, 'hB, 0); commit();
    drive(1, 'hC, 0); commit();
    reset_i = 1'b1;
    drive(1, 'hD, 0);
    checks++; if (v_o !== 1'b0 || ready_o !== 1'b0) begin failures++; $display("FAIL midreset_out v=%0b ready=%0b exp 0 0", v_o, ready_o); end
    commit();
    reset_i = 1'b0;
    drive(1, 'hE, 1);
    checks++; if (v_o !== 1'b1 || data_o !== W'('hE) || ready_o !== 1'b1) begin failures++; $display("FAIL midreset_bypass v=%0b data=%h ready=%0b exp v=1 data=e ready=1", v_o, data_o, ready_o); end
    commit();
    drive(0, '0, 0);
    checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL midreset_stale v=%0b data=%h exp v=0", v_o, data_o); end
  endtask

  task automatic test_random();
    int errs = 0;
    int consumed = 0;
    logic [W-1:0] d;
    bit v, y, ev;
    for (int c = 0; c < 10000; c++) begin
      v = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom, $urandom, $urandom};
      ev = v || (q.size() > 0);
      y = ev ? 1'($urandom_range(0, 1)) : 1'b0;
      drive(v, d, y);
      if (v_o !== ev || ready_o !== (q.size() < 2) || (ev && data_o !== exp_data())) begin
        errs++;
        if (errs <= 5) $display("FAIL random_cycle%0d v=%0b ready=%0b data=%h exp v=%0b ready=%0b data=%h",
                                c, v_o, ready_o, data_o, ev, q.size() < 2, exp_data());
      end
      if (y) consumed++;
      commit();
    end
    checks++; if (errs != 0) begin failures++; $display("FAIL random_total errors=%0d exp=0", errs); end
    checks++; if (consumed == 0) begin failures++; $display("FAIL random_consumed got=0 exp>0"); end
    drive(0, '0, 0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_bypass();
    test_fill();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
